// File: rtl/de_pkg.sv
// de_pkg: shared definitions for the dice roller.
//   - the eight legal face counts of the switch-to-face translator
//   - FSM state encoding (IDLE / SPIN / REDUCE)
//   - LFSR width, Galois tap mask and default seed
//   - face_to_onehot(): 7-bit face count to 8-bit one-hot LED code.
//     Any value that is not a legal face count returns 8'h00.
`timescale 1ns/1ps
package de_pkg;

  localparam int             LFSR_W    = 16;
  localparam logic [15:0]    LFSR_TAPS = 16'hB400;
  localparam logic [15:0]    LFSR_SEED = 16'hACE1;

  localparam logic [6:0] FACE_4   = 7'd4;
  localparam logic [6:0] FACE_6   = 7'd6;
  localparam logic [6:0] FACE_8   = 7'd8;
  localparam logic [6:0] FACE_10  = 7'd10;
  localparam logic [6:0] FACE_12  = 7'd12;
  localparam logic [6:0] FACE_20  = 7'd20;
  localparam logic [6:0] FACE_30  = 7'd30;
  localparam logic [6:0] FACE_100 = 7'd100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    REDUCE = 2'd2
  } state_t;

  function automatic logic [7:0] face_to_onehot(input logic [6:0] face);
    logic [7:0] oh;
    oh = 8'h00;
    case (face)
      FACE_4:   oh = 8'b0000_0001;
      FACE_6:   oh = 8'b0000_0010;
      FACE_8:   oh = 8'b0000_0100;
      FACE_10:  oh = 8'b0000_1000;
      FACE_12:  oh = 8'b0001_0000;
      FACE_20:  oh = 8'b0010_0000;
      FACE_30:  oh = 8'b0100_0000;
      FACE_100: oh = 8'b1000_0000;
      default:  oh = 8'h00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/de_lfsr.sv
// de_lfsr: free-running 16-bit Galois LFSR, shifting right with tap mask
// LFSR_TAPS. Advances every clock; a nonzero SEED keeps it out of the
// all-zero lock-up state.
// Ports:
//   Clk   - system clock
//   Rst   - asynchronous active-high reset, loads SEED
//   state - current LFSR contents
`timescale 1ns/1ps
module de_lfsr
  import de_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // The bit shifted out selects whether the tap mask is folded back in.
  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/de_roller.sv
// de_roller: dice roller. Holding Roll spins the LFSR; releasing it samples
// the low LFSR byte, which is reduced modulo the latched face count by
// repeated subtraction, giving Result in 1..NB_Face.
// Ports:
//   Clk      - system clock
//   Rst      - asynchronous active-high reset
//   NB_Face  - face count (legal: 4,6,8,10,12,20,30,100)
//   Roll     - debounced, Clk-synchronous roll button level
//   Result   - rolled value, 0 after reset
//   Valid    - Result holds a finished roll
//   Busy     - roll in progress (SPIN or REDUCE)
//   Face_LED - registered one-hot decode of NB_Face
// Optional build macro DE_ANIM_EN: Result counts 1..NbL during SPIN, stepping
// on each wrap of an ANIM_DIV-bit prescaler.
`timescale 1ns/1ps
module de_roller
  import de_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
`ifdef DE_ANIM_EN
  , parameter int ANIM_DIV = 20
`endif
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [6:0] NB_Face,
  input  logic       Roll,
  output logic [6:0] Result,
  output logic       Valid,
  output logic       Busy,
  output logic [7:0] Face_LED
);

  logic [15:0] lfsr_state;
  logic [7:0]  lfsr_hi_unused;

  state_t      state_q, state_d;
  logic        roll_q;
  logic [6:0]  nbl_q, nbl_d;
  logic [7:0]  acc_q, acc_d;
  logic [6:0]  result_q, result_d;
  logic        valid_q, valid_d;
  logic [7:0]  led_q;
  logic        face_legal;

`ifdef DE_ANIM_EN
  logic [ANIM_DIV-1:0] pre_q, pre_d;
`endif

  de_lfsr #(.SEED(SEED)) u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .state (lfsr_state)
  );

  // Only the low byte feeds the reduction.
  assign lfsr_hi_unused = lfsr_state[15:8];

  assign face_legal = (face_to_onehot(NB_Face) != 8'h00);

  always_comb begin
    state_d  = state_q;
    nbl_d    = nbl_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = valid_q;
`ifdef DE_ANIM_EN
    pre_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (Roll && !roll_q && face_legal) begin
          nbl_d   = NB_Face;
          valid_d = 1'b0;
          state_d = SPIN;
`ifdef DE_ANIM_EN
          result_d = 7'd1;
`endif
        end
      end
      SPIN: begin
        if (!Roll) begin
          acc_d   = lfsr_state[7:0];
          state_d = REDUCE;
        end
`ifdef DE_ANIM_EN
        else begin
          pre_d = pre_q + 1'b1;
          if (&pre_q)
            result_d = (result_q >= nbl_q) ? 7'd1 : result_q + 7'd1;
        end
`endif
      end
      REDUCE: begin
        // acc < nbl <= 100 on exit, so acc+1 always fits in 7 bits.
        if (acc_q >= {1'b0, nbl_q}) begin
          acc_d = acc_q - {1'b0, nbl_q};
        end else begin
          result_d = acc_q[6:0] + 7'd1;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and outputs: async reset. roll_q resets high so a button already
  // held at reset release is not taken as a rising edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      roll_q   <= 1'b1;
      result_q <= '0;
      valid_q  <= 1'b0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      roll_q   <= Roll;
      result_q <= result_d;
      valid_q  <= valid_d;
      led_q    <= face_to_onehot(NB_Face);
    end
  end

  // Working data is always written before use, so it needs no reset.
  always_ff @(posedge Clk) begin
    nbl_q <= nbl_d;
    acc_q <= acc_d;
  end

`ifdef DE_ANIM_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`endif

  assign Result   = result_q;
  assign Valid    = valid_q;
  assign Busy     = (state_q != IDLE);
  assign Face_LED = led_q;

endmodule

// File: tb/tb_de_roller.sv
`timescale 1ns/1ps
module tb_de_roller;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [6:0] NB_Face = 7'd0;
  logic       Roll = 1'b0;
  logic [6:0] Result;
  logic       Valid;
  logic       Busy;
  logic [7:0] Face_LED;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int last_res = 0;
  logic [15:0] m_lfsr;
  logic vprev = 1'b0;

  de_roller #(.SEED(SEED)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .NB_Face  (NB_Face),
    .Roll     (Roll),
    .Result   (Result),
    .Valid    (Valid),
    .Busy     (Busy),
    .Face_LED (Face_LED)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: right-shifting Galois, mask B400, restarts at SEED.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) m_lfsr <= SEED;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising edge of Valid pops one expected result.
  always @(negedge Clk) begin
    if (Rst) begin
      vprev = 1'b0;
    end else begin
      if (Valid && !vprev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("result", int'(Result), e);
        end
      end
      vprev = Valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Rising edge of Roll in IDLE with a legal face: Busy next cycle, Valid cleared.
  task automatic start_roll(input logic [6:0] nb);
    NB_Face = nb;
    Roll    = 1'b1;
    tick(1);
    check("busy_on_start", int'(Busy), 1);
    check("valid_clr_on_start", int'(Valid), 0);
  endtask

  // Drop Roll; the next edge samples the model's current low byte.
  // Checks exact latency: byte/nb subtractions plus sample and finish cycles.
  task automatic release_roll(input int nb);
    int b, e, cnt;
    b   = int'(m_lfsr[7:0]);
    e   = (b % nb) + 1;
    exp_q.push_back(e);
    last_res = e;
    Roll = 1'b0;
    cnt = 0;
    while (cnt < 70) begin
      tick(1);
      cnt++;
      if (Valid) break;
    end
    check("valid_latency", cnt, b / nb + 2);
    check("busy_after_done", int'(Busy), 0);
  endtask

  // Hold Roll in SPIN until the model's low byte equals target.
  task automatic spin_until_byte(input int target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (int'(m_lfsr[7:0]) == target) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] faces [8];
    bit found;
    faces = '{7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd20, 7'd30, 7'd100};

    // 1. Reset values and Face_LED decode
    Rst = 1'b1;
    tick(2);
    check("rst_result", int'(Result), 0);
    check("rst_valid", int'(Valid), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_led", int'(Face_LED), 0);
    Rst = 1'b0;
    tick(1);
    check("led_nb0", int'(Face_LED), 0);
    NB_Face = 7'd20;
    #1;
    check("led_latency", int'(Face_LED), 0);
    tick(1);
    check("led_20", int'(Face_LED), 8'b0010_0000);
    for (int i = 0; i < 8; i++) begin
      NB_Face = faces[i];
      tick(1);
      check("led_table", int'(Face_LED), 1 << i);
    end
    NB_Face = 7'd7;
    tick(1);
    check("led_illegal", int'(Face_LED), 0);

    // 2. Ordinary roll on a d6
    start_roll(7'd6);
    tick(9);
    check("busy_spin", int'(Busy), 1);
    release_roll(6);
    tick(2);
    check("valid_hold", int'(Valid), 1);

    // 3. Worst case byte 255 on a d4, then byte 0 on a d100
    start_roll(7'd4);
    spin_until_byte(255, found);
    check("found_byte255", int'(found), 1);
    release_roll(4);
    check("worst_result", int'(Result), 4);
    start_roll(7'd100);
    spin_until_byte(0, found);
    check("found_byte0", int'(found), 1);
    release_roll(100);
    check("min_result", int'(Result), 1);

    // 4. Illegal face count is ignored
    NB_Face = 7'd5;
    Roll = 1'b1;
    tick(1);
    check("illegal_busy", int'(Busy), 0);
    Roll = 1'b0;
    tick(2);
    check("illegal_busy2", int'(Busy), 0);
    check("illegal_valid", int'(Valid), 1);
    check("illegal_result", int'(Result), last_res);
    check("illegal_led", int'(Face_LED), 0);

    // 5. Roll held through reset release; NB_Face change mid-SPIN
    Roll = 1'b1;
    NB_Face = 7'd6;
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    tick(3);
    check("held_no_roll", int'(Busy), 0);
    Roll = 1'b0;
    tick(1);
    start_roll(7'd6);
    tick(3);
    NB_Face = 7'd30;
    tick(2);
    check("led_30", int'(Face_LED), 8'b0100_0000);
    release_roll(6);
    check("bounded_by_6", int'(Result <= 7'd6), 1);

    // 6. Reset during REDUCE clears outputs at once; LFSR restarts
    start_roll(7'd4);
    spin_until_byte(200, found);
    check("found_byte200", int'(found), 1);
    Roll = 1'b0;
    @(posedge Clk);
    #1;
    check("in_reduce", int'(Busy), 1);
    Rst = 1'b1;
    #1;
    check("async_busy", int'(Busy), 0);
    check("async_valid", int'(Valid), 0);
    check("async_result", int'(Result), 0);
    tick(1);
    Rst = 1'b0;
    tick(1);
    start_roll(7'd8);
    tick(4);
    release_roll(8);

    tick(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
